siso_frame_buffer: RTL and testbench

Double-banked input frame buffer for the SISO decoder. It accepts the interleaved systematic/parity sample stream and the per-bit a-priori stream, and stores one code block per bank. Each stored block is replayed to the decoder core once per recursion pass, in forward order for alpha or reverse order for beta. It sits between the top-level input ports and the branch-metric stage, so block N+1 loads while block N is being decoded.

---
 rtl/siso_pkg.sv | 15 +
 rtl/siso_bank_ram.sv | 23 ++
 rtl/siso_frame_buffer.sv | 206 ++++++++++++++++++++
 tb/tb_siso_frame_buffer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// Shared types and constants for the SISO input frame buffer.
package siso_pkg;
  localparam int MIN_BLKLEN = 1;
  localparam int NUM_BANKS  = 2;
  // Field width baked into triple_t; the top's DATA_W must equal this.
  localparam int SISO_DW    = 16;

  typedef enum logic [1:0] {EMPTY, LOADING, FULL, READING} bank_state_t;

  typedef struct packed {
    logic signed [SISO_DW-1:0] sys;
    logic signed [SISO_DW-1:0] par;
    logic signed [SISO_DW-1:0] apr;
  } triple_t;
endpackage

// File: rtl/siso_bank_ram.sv
// One bank of triple storage: simple dual-port RAM, 1-cycle synchronous read.
module siso_bank_ram #(
  parameter int DEPTH = 6144,
  parameter int W     = 48,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // registered read port
  always_ff @(posedge clk)
    rdata <= mem[raddr];
endmodule

// File: rtl/siso_frame_buffer.sv
// Double-banked SISO input frame buffer: loads one code block per bank from the
// interleaved sys/par stream plus a-priori stream, replays it per recursion pass.
// Optional feature macro: SISO_FRAME_BUFFER_REVERSE_EN enables reverse passes
// (rd_dir=1); without it every pass is forward and rd_dir is ignored.
module siso_frame_buffer
  import siso_pkg::*;
#(
  parameter int DATA_W     = SISO_DW,
  parameter int MAX_BLKLEN = 6144,
  parameter int LEN_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LEN_W-1:0]         blklen,
  input  logic                     valid_blklen,
  input  logic signed [DATA_W-1:0] in,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] apriori,
  input  logic                     valid_apriori,
  output logic                     ready,
  input  logic                     rd_start,
  input  logic                     rd_dir,
  input  logic                     rel,
  output logic signed [DATA_W-1:0] sys_out,
  output logic signed [DATA_W-1:0] par_out,
  output logic signed [DATA_W-1:0] apr_out,
  output logic [LEN_W-1:0]         idx_out,
  output logic                     valid_out,
  output logic                     last_out,
  output logic [1:0]               num_full,
  output logic                     err
);
  localparam int AW = $clog2(MAX_BLKLEN);

  bank_state_t st [NUM_BANKS];
  bank_state_t st_n [NUM_BANKS];
  logic [LEN_W-1:0] len [NUM_BANKS];
  logic             ld_bank, old_bank, phase;
  logic [LEN_W-1:0] wr_ptr;
  logic signed [DATA_W-1:0] sys_cap;
  logic             rd_bank, out_bank;
  logic [LEN_W-1:0] rd_addr, rd_rem, idx_q;
  logic             last_q;
  logic [1:0]       vld_pipe;  // [0] address issue stage, [1] RAM data stage
  triple_t          rdata [NUM_BANKS];
  triple_t          wword;

  logic loading, any_empty, any_full, any_reading, reading_bank;
  logic in_range, blk_acc, new_bank, sys_ok, par_ok, done;
  logic sel_bank, rd_acc, err_n;

`ifdef SISO_FRAME_BUFFER_REVERSE_EN
  logic rd_rev;
`else
  logic rd_dir_unused;
  assign rd_dir_unused = rd_dir;
`endif

  // bank status decode and command acceptance
  always_comb begin
    loading      = 1'b0;
    any_empty    = 1'b0;
    any_full     = 1'b0;
    any_reading  = 1'b0;
    reading_bank = (st[1] == READING);
    for (int b = 0; b < NUM_BANKS; b++) begin
      loading     |= (st[b] == LOADING);
      any_empty   |= (st[b] == EMPTY);
      any_full    |= (st[b] == FULL);
      any_reading |= (st[b] == READING);
    end
    in_range = (blklen >= LEN_W'(MIN_BLKLEN)) && (blklen <= LEN_W'(MAX_BLKLEN));
    ready    = any_empty && !loading;
    blk_acc  = valid_blklen && ready && in_range;
    new_bank = (st[0] != EMPTY);
    sys_ok   = loading && !phase && valid_in;
    par_ok   = loading && phase && valid_in && valid_apriori;
    done     = par_ok && ((wr_ptr + LEN_W'(1)) == len[ld_bank]);
    // a bank already in READING is replayed; otherwise the oldest FULL one
    if (any_reading)                             sel_bank = reading_bank;
    else if (st[0] == FULL && st[1] == FULL)     sel_bank = old_bank;
    else                                         sel_bank = (st[1] == FULL);
    rd_acc = rd_start && !(|vld_pipe) && (any_full || any_reading);
    err_n  = (valid_blklen && !blk_acc) ||
             (valid_in && !loading) ||
             (loading && phase && valid_in && !valid_apriori) ||
             (valid_apriori && !(loading && phase && valid_in)) ||
             (rd_start && !rd_acc);
  end

  // bank state next-state logic
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      st_n[b] = st[b];
      if (blk_acc && new_bank == 1'(b))        st_n[b] = LOADING;
      if (done && ld_bank == 1'(b))            st_n[b] = FULL;
      if (rd_acc && sel_bank == 1'(b))         st_n[b] = READING;
      if (rel && st[b] == READING)             st_n[b] = EMPTY;
    end
  end

  // bank state register
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int b = 0; b < NUM_BANKS; b++) st[b] <= EMPTY;
    else     for (int b = 0; b < NUM_BANKS; b++) st[b] <= st_n[b];

  // loader: sample phase, write pointer, per-bank length, load order
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ld_bank  <= 1'b0;
      old_bank <= 1'b0;
      phase    <= 1'b0;
      wr_ptr   <= '0;
      sys_cap  <= '0;
      for (int b = 0; b < NUM_BANKS; b++) len[b] <= '0;
    end else begin
      if (blk_acc) begin
        ld_bank       <= new_bank;
        wr_ptr        <= '0;
        phase         <= 1'b0;
        len[new_bank] <= blklen;
      end
      if (sys_ok) begin
        sys_cap <= in;
        phase   <= 1'b1;
      end
      if (par_ok) begin
        phase  <= 1'b0;
        wr_ptr <= wr_ptr + LEN_W'(1);
      end
      // a bank finishing while the other is still FULL is the younger one
      if (done) old_bank <= (st[~ld_bank] == FULL) ? ~ld_bank : ld_bank;
    end

  assign wword = '{sys: sys_cap, par: in, apr: apriori};

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    siso_bank_ram #(.DEPTH(MAX_BLKLEN), .W($bits(triple_t))) u_ram (
      .clk   (clk),
      .we    (par_ok && ld_bank == 1'(b)),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (wword),
      .raddr (rd_addr[AW-1:0]),
      .rdata (rdata[b])
    );
  end

  // reader: address sequencing and 2-stage valid pipeline
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_pipe <= '0;
      rd_bank  <= 1'b0;
      out_bank <= 1'b0;
      rd_addr  <= '0;
      rd_rem   <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
`ifdef SISO_FRAME_BUFFER_REVERSE_EN
      rd_rev   <= 1'b0;
`endif
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      out_bank    <= rd_bank;
      idx_q       <= vld_pipe[0] ? rd_addr : '0;
      last_q      <= vld_pipe[0] && (rd_rem == '0);
      if (rd_acc) begin
        vld_pipe[0] <= 1'b1;
        rd_bank     <= sel_bank;
        rd_rem      <= len[sel_bank] - LEN_W'(1);
`ifdef SISO_FRAME_BUFFER_REVERSE_EN
        rd_rev      <= rd_dir;
        rd_addr     <= rd_dir ? len[sel_bank] - LEN_W'(1) : '0;
`else
        rd_addr     <= '0;
`endif
      end else if (vld_pipe[0]) begin
        if (rd_rem == '0) vld_pipe[0] <= 1'b0;
        rd_rem <= rd_rem - LEN_W'(1);
`ifdef SISO_FRAME_BUFFER_REVERSE_EN
        rd_addr <= rd_rev ? rd_addr - LEN_W'(1) : rd_addr + LEN_W'(1);
`else
        rd_addr <= rd_addr + LEN_W'(1);
`endif
      end
    end

  // protocol error pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) err <= 1'b0;
    else     err <= err_n;

  // count of banks holding a complete block
  always_comb begin
    num_full = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (st[b] == FULL || st[b] == READING) num_full = num_full + 2'd1;
  end

  // RAM output is not reset, so data is forced to zero outside valid cycles
  assign valid_out = vld_pipe[1];
  assign last_out  = last_q;
  assign idx_out   = idx_q;
  assign sys_out   = vld_pipe[1] ? rdata[out_bank].sys : '0;
  assign par_out   = vld_pipe[1] ? rdata[out_bank].par : '0;
  assign apr_out   = vld_pipe[1] ? rdata[out_bank].apr : '0;
endmodule

// File: tb/tb_siso_frame_buffer.sv
// Scoreboard bench for siso_frame_buffer: directed loads/replays with
// hand-derived sample patterns; a forked monitor checks every replayed triple.
module tb_siso_frame_buffer;
  logic clk, rst;
  logic [15:0] blklen;
  logic valid_blklen, valid_in, valid_apriori, ready, rd_start, rd_dir, rel;
  logic signed [15:0] in, apriori, sys_out, par_out, apr_out;
  logic [15:0] idx_out;
  logic valid_out, last_out, err;
  logic [1:0] num_full;

  int checks = 0, errors = 0, err_cnt = 0;

  typedef struct { int s; int p; int a; int idx; bit last; } exp_t;
  exp_t sbq[$];

  siso_frame_buffer dut (
    .clk(clk), .rst(rst), .blklen(blklen), .valid_blklen(valid_blklen),
    .in(in), .valid_in(valid_in), .apriori(apriori), .valid_apriori(valid_apriori),
    .ready(ready), .rd_start(rd_start), .rd_dir(rd_dir), .rel(rel),
    .sys_out(sys_out), .par_out(par_out), .apr_out(apr_out), .idx_out(idx_out),
    .valid_out(valid_out), .last_out(last_out), .num_full(num_full), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sample patterns: 0 = {2k, 2k+1, -k}
  function automatic int fs(int p, int k);
    case (p) 0: return 2*k; 1: return k; 2: return -k; default: return 100+k; endcase
  endfunction
  function automatic int fp(int p, int k);
    case (p) 0: return 2*k+1; 1: return -k; 2: return k+5; default: return 200+k; endcase
  endfunction
  function automatic int fa(int p, int k);
    case (p) 0: return -k; 1: return k+100; 2: return 7; default: return 300+k; endcase
  endfunction

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(posedge clk); #2;
      if (!rst) begin
        if (err) err_cnt++;
        if (valid_out) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            if (errors <= 20) $display("FAIL unexpected_valid idx %0d", idx_out);
          end else begin
            e = sbq.pop_front();
            if (int'(sys_out) != e.s || int'(par_out) != e.p || int'(apr_out) != e.a ||
                int'(idx_out) != e.idx || last_out != e.last) begin
              errors++;
              if (errors <= 20)
                $display("FAIL triple got %0d/%0d/%0d idx %0d last %0b expected %0d/%0d/%0d idx %0d last %0b",
                         sys_out, par_out, apr_out, idx_out, last_out, e.s, e.p, e.a, e.idx, e.last);
            end
          end
        end
      end
    end
  endtask

  task automatic start_blk(int L);
    blklen = 16'(L); valid_blklen = 1'b1; cyc(); valid_blklen = 1'b0;
  endtask
  task automatic smp_sys(int p, int k);
    in = 16'(fs(p, k)); valid_in = 1'b1; cyc(); valid_in = 1'b0;
  endtask
  task automatic smp_par(int p, int k);
    in = 16'(fp(p, k)); apriori = 16'(fa(p, k));
    valid_in = 1'b1; valid_apriori = 1'b1; cyc(); valid_in = 1'b0; valid_apriori = 1'b0;
  endtask
  task automatic send(int p, int k0, int k1);
    for (int k = k0; k < k1; k++) begin
      smp_sys(p, k);
      if (k % 5 == 2) cyc();
      smp_par(p, k);
    end
  endtask
  task automatic push_pass(int p, int L, bit dir);
    bit rev;
`ifdef SISO_FRAME_BUFFER_REVERSE_EN
    rev = dir;
`else
    rev = 1'b0;
`endif
    for (int i = 0; i < L; i++) begin
      int k;
      k = rev ? L-1-i : i;
      sbq.push_back('{s: fs(p, k), p: fp(p, k), a: fa(p, k), idx: k, last: (i == L-1)});
    end
  endtask
  // one replay pass; ends on the first cycle a new rd_start may be accepted
  task automatic do_pass(int p, int L, bit dir, bit poke);
    int c;
    push_pass(p, L, dir);
    rd_start = 1'b1; rd_dir = dir; cyc(); rd_start = 1'b0; rd_dir = 1'b0;
    chk("lat_t1_valid", valid_out, 0);
    cyc();
    chk("lat_t2_valid", valid_out, 1);
    c = 0;
    while (sbq.size() != 0 && c < L + 8) begin cyc(); c++; end
    chk("pass_drained", sbq.size(), 0);
    if (poke) begin
      rd_start = 1'b1; cyc(); rd_start = 1'b0;
      chk("busy_rd_err", err, 1);
    end else cyc();
  endtask
  task automatic rel_bank();
    rel = 1'b1; cyc(); rel = 1'b0;
  endtask

  initial begin
    int e0, c;
    rst = 1'b1; blklen = '0; valid_blklen = 1'b0; in = '0; valid_in = 1'b0;
    apriori = '0; valid_apriori = 1'b0; rd_start = 1'b0; rd_dir = 1'b0; rel = 1'b0;
    fork monitor(); join_none
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("rst_ready", ready, 1);
    chk("rst_num_full", num_full, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_last", last_out, 0);
    chk("rst_err", err, 0);
    chk("rst_sys", sys_out, 0);
    chk("rst_idx", idx_out, 0);

    // L=512 load, forward, reverse, forward with a busy rd_start at pass end
    start_blk(512);
    chk("loading_ready", ready, 0);
    send(0, 0, 512);
    chk("full_num", num_full, 1);
    chk("full_ready", ready, 1);
    do_pass(0, 512, 1'b0, 1'b0);
    do_pass(0, 512, 1'b1, 1'b0);
    do_pass(0, 512, 1'b0, 1'b1);
    chk("reading_num", num_full, 1);
    rel_bank();
    chk("rel_num", num_full, 0);

    // rd_start with nothing to replay
    rd_start = 1'b1; cyc(); rd_start = 1'b0;
    chk("rd_none_err", err, 1);
    cyc(); cyc();
    chk("rd_none_valid", valid_out, 0);

    // out-of-range lengths
    e0 = err_cnt;
    start_blk(0);
    chk("len0_err", err, 1);
    start_blk(6145);
    chk("len6145_err", err, 1);
    cyc();
    chk("len_err_count", err_cnt - e0, 2);
    chk("len_ready", ready, 1);
    chk("len_num", num_full, 0);

    // L=4 with stray a-priori, missing a-priori and idle samples
    e0 = err_cnt;
    start_blk(4);
    apriori = 16'sd555; valid_apriori = 1'b1; cyc(); valid_apriori = 1'b0;
    chk("apr_sys_err", err, 1);
    send(3, 0, 2);
    smp_sys(3, 2);
    in = 16'sd999; valid_in = 1'b1; cyc(); valid_in = 1'b0;
    chk("par_noapr_err", err, 1);
    smp_par(3, 2);
    send(3, 3, 4);
    chk("l4_num", num_full, 1);
    in = 16'sd1; valid_in = 1'b1; cyc(); valid_in = 1'b0;
    chk("idle_in_err", err, 1);
    cyc();
    chk("l4_err_count", err_cnt - e0, 3);
    do_pass(3, 4, 1'b0, 1'b0);
    rel_bank();

    // L=1: valid and last together
    start_blk(1);
    send(0, 0, 1);
    do_pass(0, 1, 1'b1, 1'b0);
    rel_bank();
    chk("l1_num", num_full, 0);

    // two max-length blocks, command while both banks occupied
    start_blk(6144);
    send(1, 0, 6144);
    start_blk(6144);
    send(2, 0, 10);
    chk("both_busy_ready", ready, 0);
    e0 = err_cnt;
    start_blk(100);
    chk("both_busy_err", err, 1);
    cyc();
    chk("both_busy_err_once", err_cnt - e0, 1);
    send(2, 10, 6144);
    chk("two_full_num", num_full, 2);
    chk("two_full_ready", ready, 0);
    do_pass(1, 6144, 1'b0, 1'b0);        // oldest bank first
    // rel and block start together: the freed bank is not yet eligible
    rel = 1'b1; blklen = 16'd8; valid_blklen = 1'b1; cyc();
    rel = 1'b0; valid_blklen = 1'b0;
    chk("rel_blk_err", err, 1);
    chk("rel_ready_next", ready, 1);
    chk("rel_num", num_full, 1);
    do_pass(2, 6144, 1'b1, 1'b0);
    rel_bank();
    chk("big_done_num", num_full, 0);

    // reset in the middle of a replay
    start_blk(512);
    send(0, 0, 512);
    push_pass(0, 512, 1'b0);
    rd_start = 1'b1; cyc(); rd_start = 1'b0;
    c = 0;
    while (!(valid_out && idx_out == 16'd100) && c < 300) begin cyc(); c++; end
    chk("reach_idx100", int'(valid_out && idx_out == 16'd100), 1);
    rst = 1'b1; #1;
    chk("mid_rst_valid", valid_out, 0);
    chk("mid_rst_sys", sys_out, 0);
    chk("mid_rst_idx", idx_out, 0);
    chk("mid_rst_num", num_full, 0);
    sbq.delete();
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("post_rst_ready", ready, 1);
    start_blk(512);
    send(0, 0, 512);
    do_pass(0, 512, 1'b0, 1'b0);

    cyc();
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
